loopback_test_ctrl: RTL and testbench

- Sequences one 64-bit counting-pattern loopback test over the fiber/PCIe datapath.
- Generates the TX pattern and drives check_start/check_en/reset of the downstream pattern checker.
- Waits for the looped-back words, samples the checker's error counter, and reports done/pass/timeout/abort status to host registers.

---
 rtl/loopback_test_ctrl.sv | 145 ++++++++++++++
 tb/tb_loopback_test_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/loopback_test_ctrl.sv
// Sequences one counting-pattern loopback test: drives the TX pattern, steers the
// downstream pattern checker, and reports done/pass/timeout/abort status.
module loopback_test_ctrl #(
    parameter int unsigned TIMEOUT = 4096,
    parameter logic [63:0] SEED    = 64'h0000_0002_0000_0001,
    parameter logic [63:0] STEP    = 64'h0000_0002_0000_0002
) (
    input  logic        t_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] test_len,
    output logic [63:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        rx_valid,
    output logic        chk_rst,
    output logic        chk_start,
    output logic        chk_en,
    input  logic [31:0] chk_err_cnt,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_flag,
    output logic        abort_flag,
    output logic [31:0] tx_cnt,
    output logic [31:0] rx_cnt,
    output logic [31:0] err_snapshot
);

    typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, SETTLE, REPORT} state_t;

    state_t      state, state_nxt;
    logic [31:0] len_q;
    logic [31:0] idle_cnt;
    logic        phase;
    logic        tx_fire;
    logic        last_word;
    logic        timed_out;

    always_comb begin
        tx_fire   = tx_valid & tx_ready;
        last_word = tx_fire && (tx_cnt + 32'd1 == len_q);
        timed_out = !rx_valid && (idle_cnt == 32'(TIMEOUT - 1));
    end

    always_ff @(posedge t_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = CLR;
            CLR:    if (phase) state_nxt = (len_q == '0) ? SETTLE : RUN;
            RUN: begin
                if (stop || timed_out) state_nxt = SETTLE;
                else if (last_word)    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (stop || timed_out || rx_cnt >= len_q) state_nxt = SETTLE;
            end
            SETTLE: if (phase) state_nxt = REPORT;
            REPORT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        chk_rst   = (state == CLR);
        chk_start = (state == RUN) || (state == DRAIN);
        chk_en    = ((state == RUN) || (state == DRAIN)) && rx_valid;
    end

    always_ff @(posedge t_clk) begin
        if (rst) begin
            tx_data      <= SEED;
            tx_valid     <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout_flag <= 1'b0;
            abort_flag   <= 1'b0;
            tx_cnt       <= '0;
            rx_cnt       <= '0;
            err_snapshot <= '0;
            len_q        <= '0;
            idle_cnt     <= '0;
            phase        <= 1'b0;
        end else begin
            // phase marks the second cycle of the two-cycle CLR and SETTLE states
            phase <= ((state == CLR) || (state == SETTLE)) ? ~phase : 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q        <= test_len;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        timeout_flag <= 1'b0;
                        abort_flag   <= 1'b0;
                        tx_cnt       <= '0;
                        rx_cnt       <= '0;
                        err_snapshot <= '0;
                    end
                end
                CLR: begin
                    tx_data  <= SEED;
                    idle_cnt <= '0;
                    if (phase && len_q != '0) tx_valid <= 1'b1;
                end
                RUN, DRAIN: begin
                    if (tx_fire) begin
                        tx_cnt  <= tx_cnt + 32'd1;
                        tx_data <= tx_data + STEP;
                        if (last_word) tx_valid <= 1'b0;
                    end
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        if (rx_cnt != '1) rx_cnt <= rx_cnt + 32'd1;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                    if (stop) begin
                        abort_flag <= 1'b1;
                        tx_valid   <= 1'b0;
                    end else if (timed_out) begin
                        timeout_flag <= 1'b1;
                        tx_valid     <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (phase) err_snapshot <= chk_err_cnt;
                end
                REPORT: begin
                    done <= 1'b1;
                    pass <= (err_snapshot == '0) && !timeout_flag && !abort_flag
                            && (rx_cnt == len_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_loopback_test_ctrl.sv
// Directed bench for loopback_test_ctrl: behavioural sink/loopback/checker models
// around the DUT, with a TX-word scoreboard and immediate-assertion checks.
module tb_loopback_test_ctrl;

    localparam int unsigned TO   = 64;
    localparam logic [63:0] SEED = 64'h0000_0002_0000_0001;
    localparam logic [63:0] STEP = 64'h0000_0002_0000_0002;

    logic        t_clk = 1'b0;
    logic        rst, start, stop, tx_ready, rx_valid;
    logic [31:0] test_len, chk_err_cnt;
    logic [63:0] tx_data;
    logic        tx_valid, chk_rst, chk_start, chk_en;
    logic        busy, done, pass, timeout_flag, abort_flag;
    logic [31:0] tx_cnt, rx_cnt, err_snapshot;

    always #5 t_clk = ~t_clk;

    loopback_test_ctrl #(.TIMEOUT(TO), .SEED(SEED), .STEP(STEP)) dut (
        .t_clk(t_clk), .rst(rst), .start(start), .stop(stop), .test_len(test_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_valid(rx_valid),
        .chk_rst(chk_rst), .chk_start(chk_start), .chk_en(chk_en), .chk_err_cnt(chk_err_cnt),
        .busy(busy), .done(done), .pass(pass), .timeout_flag(timeout_flag),
        .abort_flag(abort_flag), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .err_snapshot(err_snapshot)
    );

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] pipe_d[3];
    logic        pipe_v[3];
    logic [63:0] rx_data;
    logic [63:0] chk_exp;
    int unsigned chk_errs;
    int          ready_mode, corrupt_idx, drop_from;
    int          hs_count, cyc, last_rx_cyc, to_cyc;
    logic        prev_stall, saw_tx_valid;
    logic [63:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        logic        hs, ce, cr;
        logic [63:0] hd, rd, w;
        int          wi;
        @(negedge t_clk);
        hs = tx_valid & tx_ready;
        hd = tx_data;
        ce = chk_en;
        cr = chk_rst;
        rd = rx_data;
        wi = hs_count;
        if (tx_valid) saw_tx_valid = 1'b1;
        if (prev_stall) begin
            check("stall_valid", 64'(tx_valid), 64'd1);
            check("stall_data", tx_data, prev_data);
        end
        prev_stall = tx_valid & !tx_ready & !stop;
        prev_data  = tx_data;
        if (hs) begin
            n_total++;
            if (exp_q.size() == 0)
                $error("FAIL tx_extra: observed word %0h expected no handshake", hd);
            else begin
                w = exp_q.pop_front();
                n_total--;
                check("tx_word", hd, w);
            end
            hs_count++;
        end
        if (to_cyc < 0 && rx_valid) last_rx_cyc = cyc;
        if (to_cyc < 0 && timeout_flag) to_cyc = cyc;
        @(posedge t_clk);
        #1;
        cyc++;
        // registered checker: resyncs its expectation to each received word
        if (rst || cr) begin
            chk_exp  = SEED;
            chk_errs = 0;
        end else if (ce) begin
            if (rd !== chk_exp) chk_errs++;
            chk_exp = rd + STEP;
        end
        chk_err_cnt = chk_errs;
        rx_valid = pipe_v[2];
        rx_data  = pipe_d[2];
        pipe_v[2] = pipe_v[1]; pipe_d[2] = pipe_d[1];
        pipe_v[1] = pipe_v[0]; pipe_d[1] = pipe_d[0];
        pipe_v[0] = hs && !rst && !(drop_from >= 0 && wi >= drop_from);
        pipe_d[0] = (wi == corrupt_idx) ? (hd ^ 64'd1) : hd;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'b0;
        endcase
    endtask

    task automatic launch(input int len, input int mode, input int cidx, input int dfrom);
        logic [63:0] w;
        test_len    = 32'(len);
        ready_mode  = mode;
        corrupt_idx = cidx;
        drop_from   = dfrom;
        tx_ready    = 1'b1;
        for (int i = 0; i < 3; i++) pipe_v[i] = 1'b0;
        exp_q.delete();
        w = SEED;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(w);
            w = w + STEP;
        end
        hs_count     = 0;
        saw_tx_valid = 1'b0;
        to_cyc       = -1;
        last_rx_cyc  = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) tick();
        check("done", 64'(done), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
    endtask

    task automatic results(input int ps, input int ntx, input int nrx, input int nerr,
                           input int tof, input int abf, input int qleft);
        check("pass", 64'(pass), 64'(ps));
        check("tx_cnt", 64'(tx_cnt), 64'(ntx));
        check("rx_cnt", 64'(rx_cnt), 64'(nrx));
        check("err_snapshot", 64'(err_snapshot), 64'(nerr));
        check("timeout_flag", 64'(timeout_flag), 64'(tof));
        check("abort_flag", 64'(abort_flag), 64'(abf));
        check("tx_q_left", 64'(exp_q.size()), 64'(qleft));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; tx_ready = 1'b1; rx_valid = 1'b0;
        test_len = '0; chk_err_cnt = '0; rx_data = '0;
        chk_exp = SEED; chk_errs = 0; ready_mode = 0; corrupt_idx = -1; drop_from = -1;
        hs_count = 0; cyc = 0; last_rx_cyc = -1; to_cyc = -1;
        prev_stall = 1'b0; saw_tx_valid = 1'b0; prev_data = '0;
        for (int i = 0; i < 3; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_tx_data", tx_data, SEED);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tx_cnt", 64'(tx_cnt), 64'd0);
        check("rst_chk_rst", 64'(chk_rst), 64'd0);

        // 4 words, ready always high; a start while busy must not relatch length
        launch(4, 0, -1, -1);
        check("busy_started", 64'(busy), 64'd1);
        tick();
        test_len = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200);
        results(1, 4, 4, 0, 0, 0, 0);

        // 8 words with tx_ready toggling every cycle
        launch(8, 1, -1, -1);
        wait_done(300);
        results(1, 8, 8, 0, 0, 0, 0);
        check("handshakes_8", 64'(hs_count), 64'd8);

        // 16 words, word 5 corrupted: bad word plus its successor are counted
        launch(16, 0, 5, -1);
        wait_done(300);
        results(0, 16, 16, 2, 0, 0, 0);

        // 10 words, last 2 dropped -> timeout
        launch(10, 0, -1, 8);
        wait_done(400);
        results(0, 10, 8, 0, 1, 0, 0);
        // flag registers on the TIMEOUT-th idle edge after the edge that took the last rx
        check("timeout_latency", 64'(to_cyc - last_rx_cyc), 64'(TO + 1));

        // stop after 3 accepted words, with the sink stalled so no 4th is taken
        launch(16, 0, -1, -1);
        for (int i = 0; i < 100 && hs_count < 3; i++) tick();
        stop = 1'b1;
        ready_mode = 2;
        tx_ready = 1'b0;
        tick();
        stop = 1'b0;
        check("stop_tx_valid", 64'(tx_valid), 64'd0);
        check("stop_abort", 64'(abort_flag), 64'd1);
        wait_done(100);
        results(0, 3, 0, 0, 0, 1, 13);

        // zero-length test, with stop in the same cycle as start (start wins)
        stop = 1'b1;
        launch(0, 0, -1, -1);
        stop = 1'b0;
        check("clr_done", 64'(done), 64'd0);
        check("clr_abort", 64'(abort_flag), 64'd0);
        check("clr_chk_rst", 64'(chk_rst), 64'd1);
        wait_done(50);
        results(1, 0, 0, 0, 0, 0, 0);
        check("len0_no_tx_valid", 64'(saw_tx_valid), 64'd0);

        // reset mid-test returns to reset values
        launch(16, 0, -1, -1);
        for (int i = 0; i < 100 && hs_count < 5; i++) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_tx_data", tx_data, SEED);
        check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        check("mid_rst_tx_cnt", 64'(tx_cnt), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
